// File: rtl/pipe_pkg.sv
// Shared pipeline-register definitions: control bundle layout, per-boundary data widths,
// and the occupancy encoding used by the skid stage.
package pipe_pkg;

    localparam int EX_W        = 5;
    localparam int MEM_W       = 2;
    localparam int WB_W        = 2;
    localparam int PIPE_CTRL_W = EX_W + MEM_W + WB_W;

    localparam int EX_LSB  = 0;
    localparam int MEM_LSB = EX_W;
    localparam int WB_LSB  = EX_W + MEM_W;

    localparam int IF_ID_DATA_W  = 64;
    localparam int ID_EX_DATA_W  = 111;
    localparam int EX_MEM_DATA_W = 69;
    localparam int MEM_WB_DATA_W = 69;

    localparam logic [PIPE_CTRL_W-1:0] NOP_CTRL = '0;

    typedef enum logic [1:0] {
        OCC_EMPTY = 2'b00,
        OCC_MAIN  = 2'b10,
        OCC_FULL  = 2'b11
    } occ_e;

    function automatic logic [1:0] occ_count(input logic main_v, input logic skid_v);
        return {1'b0, main_v} + {1'b0, skid_v};
    endfunction

endpackage

// File: rtl/pipe_stage_skid_if.sv
// Valid/ready handshake carrying one control bundle and one data bundle.
interface pipe_stage_skid_if #(
    parameter int CTRL_W = 9,
    parameter int DATA_W = 111
);
    logic              valid;
    logic              ready;
    logic [CTRL_W-1:0] ctrl;
    logic [DATA_W-1:0] data;

    modport master (output valid, output ctrl, output data, input  ready);
    modport slave  (input  valid, input  ctrl, input  data, output ready);
endinterface

// File: rtl/pipe_entry.sv
// One storage slot of the skid stage: valid bit, control register and data register
// with load, synchronous clear and asynchronous reset.
module pipe_entry #(
    parameter int CTRL_W     = 9,
    parameter int DATA_W     = 111,
    parameter bit CLEAR_DATA = 1'b1
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              clear,
    input  logic              load,
    input  logic              valid_in,
    input  logic [CTRL_W-1:0] ctrl_in,
    input  logic [DATA_W-1:0] data_in,
    output logic              valid_q,
    output logic [CTRL_W-1:0] ctrl_q,
    output logic [DATA_W-1:0] data_q
);

  logic              valid_d;
  logic [CTRL_W-1:0] ctrl_d;
  logic [DATA_W-1:0] data_d;

  // clear wins over load so a flushed cycle can never capture the incoming entry
  always_comb begin
    valid_d = valid_in;
    ctrl_d  = ctrl_q;
    data_d  = data_q;
    if (clear) begin
      valid_d = 1'b0;
      ctrl_d  = '0;
      data_d  = CLEAR_DATA ? '0 : data_q;
    end else if (load) begin
      ctrl_d = ctrl_in;
      data_d = data_in;
    end else begin
      ctrl_d = ctrl_q;
      data_d = data_q;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      valid_q <= 1'b0;
      ctrl_q  <= '0;
    end else begin
      valid_q <= valid_d;
      ctrl_q  <= ctrl_d;
    end
  end

  generate
    if (CLEAR_DATA) begin : g_data_rst
      always_ff @(posedge clk or posedge rst) begin
        if (rst) data_q <= '0;
        else     data_q <= data_d;
      end
    end else begin : g_data_keep
      // no reset on the wide data path; the gated ctrl makes stale data harmless
      always_ff @(posedge clk) begin
        data_q <= data_d;
      end
    end
  endgenerate

endmodule

// File: rtl/pipe_stage_skid.sv
// Pipeline stage register with valid/ready flow control, flush-to-bubble and a
// 2-entry skid buffer so in_ready comes straight from a flop.
module pipe_stage_skid
  import pipe_pkg::*;
#(
    parameter int CTRL_W     = PIPE_CTRL_W,
    parameter int DATA_W     = ID_EX_DATA_W,
    parameter bit CLEAR_DATA = 1'b1
) (
    input  logic                clk,
    input  logic                rst,
    input  logic                flush,
    pipe_stage_skid_if.slave    up,
    pipe_stage_skid_if.master   dn,
    output logic [1:0]          occupancy
);

  logic              main_valid_q, skid_valid_q;
  logic [CTRL_W-1:0] main_ctrl_q,  skid_ctrl_q;
  logic [DATA_W-1:0] main_data_q,  skid_data_q;

  logic              main_valid_d, skid_valid_d;
  logic              main_load,    skid_load, main_from_skid;
  logic              accept,       pop;
  logic [CTRL_W-1:0] main_ctrl_in;
  logic [DATA_W-1:0] main_data_in;
  occ_e              occ_state;

  // transfer decisions from the current occupancy, accept and pop
  always_comb begin
    accept         = up.valid & ~skid_valid_q;
    pop            = main_valid_q & dn.ready;
    occ_state      = occ_e'({main_valid_q, skid_valid_q});
    main_valid_d   = main_valid_q;
    skid_valid_d   = skid_valid_q;
    main_load      = 1'b0;
    skid_load      = 1'b0;
    main_from_skid = 1'b0;
    case (occ_state)
      OCC_EMPTY: begin
        main_load    = accept;
        main_valid_d = accept;
      end
      OCC_MAIN: begin
        if (pop) begin
          main_load    = accept;
          main_valid_d = accept;
        end else begin
          skid_load    = accept;
          skid_valid_d = accept;
        end
      end
      OCC_FULL: begin
        if (pop) begin
          main_load      = 1'b1;
          main_from_skid = 1'b1;
          skid_valid_d   = 1'b0;
        end else begin
          main_load = 1'b0;
        end
      end
      default: begin
        main_valid_d = 1'b0;
        skid_valid_d = 1'b0;
      end
    endcase
    main_ctrl_in = main_from_skid ? skid_ctrl_q : up.ctrl;
    main_data_in = main_from_skid ? skid_data_q : up.data;
  end

  pipe_entry #(.CTRL_W(CTRL_W), .DATA_W(DATA_W), .CLEAR_DATA(CLEAR_DATA)) u_main (
      .clk      (clk),
      .rst      (rst),
      .clear    (flush),
      .load     (main_load),
      .valid_in (main_valid_d),
      .ctrl_in  (main_ctrl_in),
      .data_in  (main_data_in),
      .valid_q  (main_valid_q),
      .ctrl_q   (main_ctrl_q),
      .data_q   (main_data_q)
  );

  pipe_entry #(.CTRL_W(CTRL_W), .DATA_W(DATA_W), .CLEAR_DATA(CLEAR_DATA)) u_skid (
      .clk      (clk),
      .rst      (rst),
      .clear    (flush),
      .load     (skid_load),
      .valid_in (skid_valid_d),
      .ctrl_in  (up.ctrl),
      .data_in  (up.data),
      .valid_q  (skid_valid_q),
      .ctrl_q   (skid_ctrl_q),
      .data_q   (skid_data_q)
  );

  // a bubble presents NOP control so no later stage writes state
  assign up.ready  = ~skid_valid_q;
  assign dn.valid  = main_valid_q;
  assign dn.ctrl   = main_valid_q ? main_ctrl_q : CTRL_W'(NOP_CTRL);
  assign dn.data   = main_data_q;
  assign occupancy = occ_count(main_valid_q, skid_valid_q);

endmodule

// File: tb/tb_pipe_stage_skid.sv
// Self-checking bench: directed scenarios plus random traffic against a 2-deep FIFO model.
module tb_pipe_stage_skid;
  localparam int CW = 9;
  localparam int DW = 111;

  typedef struct packed {
    logic [CW-1:0] c;
    logic [DW-1:0] d;
  } ent_t;

  logic          clk;
  logic          rst;
  logic          flush;
  logic          in_valid;
  logic          out_ready;
  logic [CW-1:0] in_ctrl;
  logic [DW-1:0] in_data;
  logic [1:0]    occ_a, occ_b;
  logic [DW-1:0] ones_d;
  logic [CW-1:0] ones_c;
  int            checks;
  int            failures;
  ent_t          q[$];

  pipe_stage_skid_if #(.CTRL_W(CW), .DATA_W(DW)) up_a ();
  pipe_stage_skid_if #(.CTRL_W(CW), .DATA_W(DW)) dn_a ();
  pipe_stage_skid_if #(.CTRL_W(CW), .DATA_W(DW)) up_b ();
  pipe_stage_skid_if #(.CTRL_W(CW), .DATA_W(DW)) dn_b ();

  assign up_a.valid = in_valid;
  assign up_a.ctrl  = in_ctrl;
  assign up_a.data  = in_data;
  assign dn_a.ready = out_ready;
  assign up_b.valid = in_valid;
  assign up_b.ctrl  = in_ctrl;
  assign up_b.data  = in_data;
  assign dn_b.ready = out_ready;

  pipe_stage_skid #(.CTRL_W(CW), .DATA_W(DW), .CLEAR_DATA(1'b1)) dut (
      .clk(clk), .rst(rst), .flush(flush), .up(up_a), .dn(dn_a), .occupancy(occ_a));

  pipe_stage_skid #(.CTRL_W(CW), .DATA_W(DW), .CLEAR_DATA(1'b0)) dut_nc (
      .clk(clk), .rst(rst), .flush(flush), .up(up_b), .dn(dn_b), .occupancy(occ_b));

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [127:0] got, input logic [127:0] exp);
    checks++;
    if (got !== exp) begin
      failures++;
      $display("FAIL %s got=%h exp=%h", tag, got, exp);
    end
  endtask

  // reference: FIFO of capacity 2, readiness judged on the pre-edge fill level
  task automatic model_edge();
    int sz;
    sz = q.size();
    if (flush) begin
      q.delete();
    end else begin
      if (sz > 0 && out_ready) void'(q.pop_front());
      if (in_valid && sz < 2) q.push_back(ent_t'{in_ctrl, in_data});
    end
  endtask

  task automatic compare_all();
    int            sz;
    logic [CW-1:0] hc;
    sz = q.size();
    hc = (sz > 0) ? q[0].c : '0;
    chk("occ_a",   128'(occ_a),       128'(sz));
    chk("valid_a", 128'(dn_a.valid),  128'(sz != 0));
    chk("ready_a", 128'(up_a.ready),  128'(sz < 2));
    chk("ctrl_a",  128'(dn_a.ctrl),   128'(hc));
    chk("occ_b",   128'(occ_b),       128'(sz));
    chk("valid_b", 128'(dn_b.valid),  128'(sz != 0));
    chk("ready_b", 128'(up_b.ready),  128'(sz < 2));
    chk("ctrl_b",  128'(dn_b.ctrl),   128'(hc));
    if (sz > 0) begin
      chk("data_a", 128'(dn_a.data), 128'(q[0].d));
      chk("data_b", 128'(dn_b.data), 128'(q[0].d));
    end
    chk("inv_full_ready",  128'(up_a.ready && occ_a == 2'd2), 128'(0));
    chk("inv_bubble_ctrl", 128'(!dn_a.valid && dn_a.ctrl != '0), 128'(0));
  endtask

  task automatic cycle(input logic v, input logic [CW-1:0] c, input logic [DW-1:0] d,
                       input logic ordy, input logic fl);
    in_valid  = v;
    in_ctrl   = c;
    in_data   = d;
    out_ready = ordy;
    flush     = fl;
    @(posedge clk);
    model_edge();
    #1;
    compare_all();
  endtask

  initial begin
    logic [127:0]  r;
    logic [CW-1:0] rc;
    checks    = 0;
    failures  = 0;
    ones_d    = '1;
    ones_c    = '1;
    rst       = 1'b1;
    flush     = 1'b0;
    in_valid  = 1'b0;
    out_ready = 1'b0;
    in_ctrl   = '0;
    in_data   = '0;
    #1;
    chk("rst_valid", 128'(dn_a.valid), 128'(0));
    chk("rst_ctrl",  128'(dn_a.ctrl),  128'(0));
    chk("rst_data",  128'(dn_a.data),  128'(0));
    chk("rst_ready", 128'(up_a.ready), 128'(1));
    chk("rst_occ",   128'(occ_a),      128'(0));
    @(negedge clk);
    rst = 1'b0;

    // streaming at full rate: one-cycle latency, occupancy stays at one
    cycle(1'b1, 9'h011, 111'hA, 1'b1, 1'b0);
    chk("t2_a", 128'(dn_a.data), 128'(111'hA));
    chk("t2_occ", 128'(occ_a), 128'(1));
    cycle(1'b1, 9'h022, 111'hB, 1'b1, 1'b0);
    chk("t2_b", 128'(dn_a.data), 128'(111'hB));
    cycle(1'b1, 9'h033, 111'hC, 1'b1, 1'b0);
    chk("t2_c", 128'(dn_a.data), 128'(111'hC));
    chk("t2_occ_c", 128'(occ_a), 128'(1));
    cycle(1'b0, 9'h000, 111'h0, 1'b1, 1'b0);

    // stall fills the skid, then drains in order
    cycle(1'b1, 9'h044, 111'h1A, 1'b0, 1'b0);
    cycle(1'b1, 9'h055, 111'h1B, 1'b0, 1'b0);
    chk("t3_ready", 128'(up_a.ready), 128'(0));
    chk("t3_occ",   128'(occ_a),      128'(2));
    chk("t3_head",  128'(dn_a.data),  128'(111'h1A));
    cycle(1'b1, 9'h066, 111'h1C, 1'b1, 1'b0);
    chk("t3_b", 128'(dn_a.data), 128'(111'h1B));
    cycle(1'b1, 9'h066, 111'h1C, 1'b1, 1'b0);
    chk("t3_c", 128'(dn_a.data), 128'(111'h1C));
    cycle(1'b0, 9'h000, 111'h0, 1'b1, 1'b0);

    // flush while full with a valid input pending
    cycle(1'b1, 9'h077, 111'h2A, 1'b0, 1'b0);
    cycle(1'b1, 9'h088, 111'h2B, 1'b0, 1'b0);
    cycle(1'b1, 9'h099, 111'h2D, 1'b0, 1'b1);
    chk("t4_valid", 128'(dn_a.valid), 128'(0));
    chk("t4_ctrl",  128'(dn_a.ctrl),  128'(0));
    chk("t4_occ",   128'(occ_a),      128'(0));
    chk("t4_ready", 128'(up_a.ready), 128'(1));
    cycle(1'b0, 9'h000, 111'h0, 1'b1, 1'b0);
    chk("t4_gone", 128'(dn_a.valid), 128'(0));

    // flush of an all-ones entry: data cleared only when CLEAR_DATA=1
    cycle(1'b1, ones_c, ones_d, 1'b0, 1'b0);
    cycle(1'b0, 9'h000, 111'h0, 1'b0, 1'b1);
    chk("t5_data_clr",  128'(dn_a.data), 128'(0));
    chk("t5_data_keep", 128'(dn_b.data), 128'(ones_d));
    chk("t5_ctrl_clr",  128'(dn_a.ctrl), 128'(0));
    chk("t5_ctrl_keep", 128'(dn_b.ctrl), 128'(0));

    // asynchronous reset in the middle of a cycle
    cycle(1'b1, 9'h0A1, 111'h3A, 1'b0, 1'b0);
    cycle(1'b1, 9'h0A2, 111'h3B, 1'b0, 1'b0);
    in_valid = 1'b0;
    #1 rst = 1'b1;
    #1;
    chk("t1_valid", 128'(dn_a.valid), 128'(0));
    chk("t1_ctrl",  128'(dn_a.ctrl),  128'(0));
    chk("t1_data",  128'(dn_a.data),  128'(0));
    chk("t1_ready", 128'(up_a.ready), 128'(1));
    chk("t1_occ",   128'(occ_a),      128'(0));
    q.delete();
    #1 rst = 1'b0;
    cycle(1'b1, 9'h0A3, 111'h3E, 1'b1, 1'b0);
    chk("t1_first", 128'(dn_a.data), 128'(111'h3E));

    // random traffic against the model
    for (int i = 0; i < 10000; i++) begin
      r  = {$urandom, $urandom, $urandom, $urandom};
      rc = 9'($urandom);
      cycle(($urandom_range(0, 3) != 0), rc, r[DW-1:0],
            ($urandom_range(0, 4) < 3), ($urandom_range(0, 31) == 0));
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
